fir_mc: RTL and testbench

Multi-channel, time-multiplexed, programmable-coefficient FIR filter: the parametrised successor to the fixed 8th-order Gaussian low-pass FIR in the same datapath. A single signed multiply-accumulate unit processes one sample at a time across `CHANNELS` independent delay lines. It adds run-time coefficient loading, valid/ready handshakes on both sides, a configurable output shift and saturation. It sits between the sample source and downstream decimation/DSP stages.

---
 rtl/fir_mc_pkg.sv | 27 ++
 rtl/fir_mc_mac.sv | 46 ++++
 rtl/fir_mc.sv | 208 ++++++++++++++++++++
 tb/tb_fir_mc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mc_pkg.sv
// Shared definitions for the multi-channel time-multiplexed FIR: state
// encoding, a constant-foldable clog2 and the reference Gaussian tap set.
package fir_mc_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_MAC  = ST_MAC,
      S_OUT  = ST_OUT
   } state_e;

   localparam int GAUSS_TAPS = 9;
   localparam int GAUSS_COEF [GAUSS_TAPS] = '{7, 17, 32, 46, 52, 46, 32, 17, 7};

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_mc_mac.sv
// Signed multiply-accumulate slice shared by all channels; the next
// accumulator value is exposed so the final tap can be captured on the same edge.
module fir_mac #(
   parameter int IN_W   = 16,
   parameter int COEF_W = 12,
   parameter int ACC_W  = 32
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic                     clr_i,
   input  logic                     en_i,
   input  logic signed [IN_W-1:0]   x_i,
   input  logic signed [COEF_W-1:0] c_i,
   output logic signed [ACC_W-1:0]  sum_o
);

   localparam int PROD_W = IN_W + COEF_W;

   logic signed [PROD_W-1:0] prod_s;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;

   assign prod_s = PROD_W'(x_i) * PROD_W'(c_i);

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + ACC_W'(prod_s);
      end else begin
         acc_d = acc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign sum_o = acc_d;

endmodule

// File: rtl/fir_mc.sv
// Multi-channel programmable FIR: one MAC walks the taps of the selected
// channel history, then the shifted, saturated result is held until taken.
module fir_mc
   import fir_mc_pkg::*;
#(
   parameter int IN_W     = 16,
   parameter int COEF_W   = 12,
   parameter int TAPS     = 9,
   parameter int CHANNELS = 4,
   parameter int CH_W     = (CHANNELS > 1) ? clog2(CHANNELS) : 1,
   parameter int ACC_W    = IN_W + COEF_W + clog2(TAPS),
   parameter int OUT_W    = 32,
   parameter int SHIFT    = 0
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CH_W-1:0]          in_ch,
   input  logic signed [IN_W-1:0]   Data_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CH_W-1:0]          out_ch,
   output logic signed [OUT_W-1:0]  Data_out,
   output logic                     out_sat,
   output logic                     ch_err,
   input  logic                     coef_we,
   input  logic [clog2(TAPS)-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     coef_busy
);

   localparam int CA_W  = clog2(TAPS);
   localparam int SAT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
   localparam logic [CA_W-1:0] LAST_TAP = CA_W'(TAPS - 1);
   localparam logic [CH_W:0]   NUM_CH   = (CH_W + 1)'(CHANNELS);
   localparam logic signed [SAT_W-1:0] SAT_MAX = SAT_W'({1'b0, {(OUT_W-1){1'b1}}});
   localparam logic signed [SAT_W-1:0] SAT_MIN = ~SAT_MAX;

   state_e                   state_q, state_d;
   logic [CA_W-1:0]          tap_q, tap_d;
   logic [CH_W-1:0]          ch_q;
   logic signed [IN_W-1:0]   hist_q [CHANNELS][TAPS];
   logic signed [COEF_W-1:0] coef_q [TAPS];

   logic                     in_ready_q, out_valid_q, out_sat_q, ch_err_q, coef_busy_q;
   logic [CH_W-1:0]          out_ch_q;
   logic signed [OUT_W-1:0]  data_q;

   logic                     accept_s, ch_ok_s, load_s, coef_wr_s;
   logic                     mac_clr_s, mac_en_s, mac_last_s;
   logic signed [IN_W-1:0]   mac_x_s;
   logic signed [COEF_W-1:0] mac_c_s;
   logic signed [ACC_W-1:0]  acc_next_s;
   logic signed [ACC_W-1:0]  shifted_s;
   logic signed [SAT_W-1:0]  wide_s;
   logic signed [OUT_W-1:0]  sat_data_s;
   logic                     sat_clip_s;

   assign accept_s   = (state_q == S_IDLE) && in_valid && in_ready_q;
   assign ch_ok_s    = ({1'b0, in_ch} < NUM_CH);
   assign load_s     = accept_s && ch_ok_s;
   assign coef_wr_s  = (state_q == S_IDLE) && coef_we;
   assign mac_last_s = (state_q == S_MAC) && (tap_q == LAST_TAP);
   assign mac_x_s    = hist_q[ch_q][tap_q];
   assign mac_c_s    = coef_q[tap_q];

   always_comb begin
      state_d   = state_q;
      tap_d     = tap_q;
      mac_clr_s = 1'b0;
      mac_en_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_s) begin
               state_d   = S_MAC;
               tap_d     = '0;
               mac_clr_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MAC: begin
            mac_en_s = 1'b1;
            if (tap_q == LAST_TAP) begin
               state_d = S_OUT;
               tap_d   = '0;
            end else begin
               tap_d = tap_q + CA_W'(1);
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_OUT;
            end
         end
         default: begin
            state_d = S_IDLE;
            tap_d   = '0;
         end
      endcase
   end

   fir_mac #(
      .IN_W   (IN_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk   (clk),
      .Reset (Reset),
      .clr_i (mac_clr_s),
      .en_i  (mac_en_s),
      .x_i   (mac_x_s),
      .c_i   (mac_c_s),
      .sum_o (acc_next_s)
   );

   // Shift then clamp in a width that holds both the accumulator and the output range.
   always_comb begin
      shifted_s = acc_next_s >>> SHIFT;
      wide_s    = SAT_W'(shifted_s);
      if (wide_s > SAT_MAX) begin
         sat_data_s = SAT_MAX[OUT_W-1:0];
         sat_clip_s = 1'b1;
      end else if (wide_s < SAT_MIN) begin
         sat_data_s = SAT_MIN[OUT_W-1:0];
         sat_clip_s = 1'b1;
      end else begin
         sat_data_s = wide_s[OUT_W-1:0];
         sat_clip_s = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         tap_q       <= '0;
         ch_q        <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         coef_busy_q <= 1'b0;
         ch_err_q    <= 1'b0;
         out_sat_q   <= 1'b0;
         out_ch_q    <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         in_ready_q  <= (state_d == S_IDLE);
         out_valid_q <= (state_d == S_OUT);
         coef_busy_q <= (state_d != S_IDLE);
         ch_err_q    <= accept_s && !ch_ok_s;
         if (load_s) begin
            ch_q <= in_ch;
         end
         if (mac_last_s) begin
            data_q    <= sat_data_s;
            out_sat_q <= sat_clip_s;
            out_ch_q  <= ch_q;
         end
      end
   end

   // Addresses at or beyond TAPS match no register, so they fall away naturally.
   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int t = 0; t < TAPS; t++) begin
            coef_q[t] <= (t == 0) ? COEF_W'(1) : '0;
         end
      end else begin
         for (int t = 0; t < TAPS; t++) begin
            if (coef_wr_s && (coef_addr == CA_W'(t))) begin
               coef_q[t] <= coef_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int t = 0; t < TAPS; t++) begin
               hist_q[c][t] <= '0;
            end
         end
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (load_s && (in_ch == CH_W'(c))) begin
               hist_q[c][0] <= Data_in;
               for (int t = 1; t < TAPS; t++) begin
                  hist_q[c][t] <= hist_q[c][t-1];
               end
            end
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign Data_out  = data_q;
   assign out_sat   = out_sat_q;
   assign ch_err    = ch_err_q;
   assign coef_busy = coef_busy_q;

endmodule

// File: tb/tb_fir_mc.sv
// Bench for fir_mc: a default instance and a 16-bit-output, 5-channel instance
// run in lockstep; "sel" chooses which one the scoreboard observes.
`timescale 1ns/1ps
module tb_fir_mc;
   import fir_mc_pkg::*;

   localparam int TAPS = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               Reset, in_valid, out_ready, coef_we, mask0, sel;
   logic [2:0]         in_ch;
   logic signed [15:0] Data_in;
   logic [3:0]         coef_addr;
   logic signed [11:0] coef_data;

   logic               ir0, ov0, sat0, err0, busy0;
   logic [1:0]         oc0;
   logic signed [31:0] do0;
   logic               ir1, ov1, sat1, err1, busy1;
   logic [2:0]         oc1;
   logic signed [15:0] do1;

   fir_mc u_dut0 (
      .clk(clk), .Reset(Reset), .in_valid(in_valid & ~mask0), .in_ready(ir0),
      .in_ch(in_ch[1:0]), .Data_in(Data_in), .out_valid(ov0), .out_ready(out_ready),
      .out_ch(oc0), .Data_out(do0), .out_sat(sat0), .ch_err(err0),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(busy0)
   );

   fir_mc #(.CHANNELS(5), .OUT_W(16)) u_dut1 (
      .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_ready(ir1),
      .in_ch(in_ch), .Data_in(Data_in), .out_valid(ov1), .out_ready(out_ready),
      .out_ch(oc1), .Data_out(do1), .out_sat(sat1), .ch_err(err1),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(busy1)
   );

   logic               ir_s, ov_s, sat_s, err_s, busy_s;
   logic [2:0]         oc_s;
   logic signed [31:0] do_s;

   always_comb begin
      if (sel) begin
         ir_s = ir1; ov_s = ov1; sat_s = sat1; err_s = err1; busy_s = busy1;
         oc_s = oc1; do_s = 32'(do1);
      end else begin
         ir_s = ir0; ov_s = ov0; sat_s = sat0; err_s = err0; busy_s = busy0;
         oc_s = {1'b0, oc0}; do_s = do0;
      end
   end

   typedef struct { logic [2:0] ch; longint data; logic sat; } exp_t;
   typedef struct { logic [2:0] ch; logic signed [15:0] din; longint exp; logic sat; } vec_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ov_s && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", do_s, e.data);
            check("out_ch", oc_s, e.ch);
            check("out_sat", sat_s, e.sat);
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!ir_s && n < 64) begin
         tick();
         n++;
      end
      if (!ir_s) check("in_ready_timeout", 0, 1);
   endtask

   task automatic send(input logic [2:0] ch, input logic signed [15:0] din,
                       input bit push, input longint e, input logic es);
      exp_t x;
      wait_ready();
      in_valid = 1'b1;
      in_ch    = ch;
      Data_in  = din;
      @(posedge clk);
      if (push) begin
         x.ch = ch; x.data = e; x.sat = es;
         exp_q.push_back(x);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic wr_coef(input logic [3:0] addr, input logic signed [11:0] data);
      coef_we   = 1'b1;
      coef_addr = addr;
      coef_data = data;
      tick();
      coef_we = 1'b0;
   endtask

   task automatic do_reset();
      Reset    = 1'b1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      exp_q.delete();
      tick();
   endtask

   initial begin
      int   g   [9] = '{7, 17, 32, 46, 52, 46, 32, 17, 7};
      int   cum [10] = '{70, 240, 560, 1020, 1540, 2000, 2320, 2490, 2560, 2560};
      vec_t tbl[$];
      vec_t v;
      int   early, seen, n;

      Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; coef_we = 1'b0;
      in_ch = 3'd0; Data_in = 16'sd0; coef_addr = 4'd0; coef_data = 12'sd0;
      mask0 = 1'b0; sel = 1'b0;

      // Reset values
      tick();
      tick();
      @(negedge clk);
      check("rst_in_ready_low", ir_s, 0);
      @(posedge clk);
      #1 Reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", ov_s, 0);
      check("rst_data_out", do_s, 0);
      check("rst_out_ch", oc_s, 0);
      check("rst_out_sat", sat_s, 0);
      check("rst_ch_err", err_s, 0);
      check("rst_coef_busy", busy_s, 0);
      tick();
      check("rst_in_ready_high", ir_s, 1);

      // Identity coefficients and result latency
      send(3'd0, 16'sd100, 1'b1, 100, 1'b0);
      early = 0;
      for (int i = 0; i < TAPS; i++) begin
         if (ov_s) early++;
         tick();
      end
      check("latency_early_valid", early, 0);
      check("latency_valid", ov_s, 1);
      drain();

      // Gaussian set, with out-of-range addresses that must be ignored
      do_reset();
      for (int i = 0; i < TAPS; i++) wr_coef(4'(i), 12'(GAUSS_COEF[i]));
      wr_coef(4'd9, 12'sd999);
      wr_coef(4'd15, -12'sd5);

      for (int i = 0; i < 10; i++) begin
         v.ch = 3'd1; v.din = (i == 0) ? 16'sd1 : 16'sd0;
         v.exp = (i < 9) ? g[i] : 0; v.sat = 1'b0;
         tbl.push_back(v);
      end
      for (int i = 0; i < 10; i++) begin
         v.ch = 3'd0; v.din = (i == 0) ? 16'sd1 : 16'sd0;
         v.exp = (i < 9) ? g[i] : 0; v.sat = 1'b0;
         tbl.push_back(v);
         v.ch = 3'd2; v.din = 16'sd10; v.exp = cum[i]; v.sat = 1'b0;
         tbl.push_back(v);
      end
      for (int i = 0; i < tbl.size(); i++) begin
         send(tbl[i].ch, tbl[i].din, 1'b1, tbl[i].exp, tbl[i].sat);
      end
      drain();

      // Backpressure: held result, no accept, dropped coefficient write
      out_ready = 1'b0;
      send(3'd3, 16'sd5, 1'b1, 35, 1'b0);
      n = 0;
      while (!ov_s && n < 32) begin
         tick();
         n++;
      end
      check("bp_valid", ov_s, 1);
      coef_we = 1'b1; coef_addr = 4'd0; coef_data = 12'sd100;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_data", do_s, 35);
         check("bp_in_ready", ir_s, 0);
         check("bp_coef_busy", busy_s, 1);
         tick();
      end
      coef_we   = 1'b0;
      out_ready = 1'b1;
      send(3'd3, 16'sd1, 1'b1, 92, 1'b0);
      drain();

      // Saturation on the 16-bit output instance
      sel = 1'b1;
      for (int i = 0; i < TAPS; i++) wr_coef(4'(i), 12'sd2047);
      for (int i = 0; i < 3; i++) send(3'd1, 16'sd32767, 1'b1, 32767, 1'b1);
      send(3'd2, -16'sd32768, 1'b1, -32768, 1'b1);
      drain();

      // Out-of-range channel on the 5-channel instance
      mask0 = 1'b1;
      send(3'd5, 16'sd1234, 1'b0, 0, 1'b0);
      @(negedge clk);
      check("ch_err_pulse", err_s, 1);
      tick();
      @(negedge clk);
      check("ch_err_one_cycle", err_s, 0);
      seen = 0;
      for (int i = 0; i < TAPS + 4; i++) begin
         if (ov_s) seen++;
         tick();
      end
      check("ch_err_no_output", seen, 0);
      check("ch_err_ready", ir_s, 1);
      mask0 = 1'b0;

      // Reset during MAC aborts the sample and restores identity
      sel = 1'b0;
      send(3'd0, 16'sd7, 1'b0, 0, 1'b0);
      tick();
      tick();
      Reset = 1'b1;
      tick();
      check("abort_in_ready_low", ir_s, 0);
      Reset = 1'b0;
      seen = 0;
      for (int i = 0; i < TAPS + 4; i++) begin
         if (ov_s) seen++;
         tick();
      end
      check("abort_no_output", seen, 0);
      send(3'd0, 16'sd100, 1'b1, 100, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
